// File: rtl/valve_cmd_scheduler_pkg.sv
// Shared types and default timing for the valve command scheduler.
// Imported by the scheduler top and its timer.
package valve_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_e;

    typedef enum logic {
        REQ_PRG = 1'b0,
        REQ_MAN = 1'b1
    } req_e;

    localparam int DEF_NUM_VALVES = 16;
    localparam int DEF_VID_W      = 4;
    localparam int DEF_SETTLE     = 50_000_000;
    localparam int DEF_GAP        = 2_000_000;
    localparam int DEF_CNT_W      = 26;

endpackage

// File: rtl/valve_cmd_scheduler_if.sv
// Requester handshakes plus servo and status outputs of the scheduler.
// master = requesters/observer side, slave = scheduler side.
interface valve_cmd_scheduler_if #(
    parameter int VID_W      = 4,
    parameter int NUM_VALVES = 16
);
    logic                  prg_valid;
    logic                  prg_ready;
    logic [VID_W-1:0]      prg_valve;
    logic                  prg_open;
    logic                  man_valid;
    logic                  man_ready;
    logic [VID_W-1:0]      man_valve;
    logic                  man_open;
    logic                  servo_en;
    logic [VID_W-1:0]      servo_ch;
    logic                  servo_open;
    logic [NUM_VALVES-1:0] valve_state;
    logic                  busy;
    logic                  cmd_done;
    logic                  cmd_err;

    modport master (
        output prg_valid, prg_valve, prg_open,
        output man_valid, man_valve, man_open,
        input  prg_ready, man_ready,
        input  servo_en, servo_ch, servo_open,
        input  valve_state, busy, cmd_done, cmd_err
    );

    modport slave (
        input  prg_valid, prg_valve, prg_open,
        input  man_valid, man_valve, man_open,
        output prg_ready, man_ready,
        output servo_en, servo_ch, servo_open,
        output valve_state, busy, cmd_done, cmd_err
    );

endinterface

// File: rtl/valve_cmd_scheduler_timer.sv
// Loadable down-counter for settle/gap timing; stops at zero.
// Load wins over decrement.
module sched_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;

    // load on state entry, otherwise count down to zero and hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/valve_cmd_scheduler.sv
// Round-robin scheduler of valve open/close commands onto one servo channel.
// Each actuation drives the servo for a settle time, then idles for a guard gap.
module valve_cmd_scheduler
    import valve_sched_pkg::*;
#(
    parameter int NUM_VALVES    = DEF_NUM_VALVES,
    parameter int VID_W         = DEF_VID_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE,
    parameter int GAP_CYCLES    = DEF_GAP,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    valve_cmd_scheduler_if.slave bus
);
    localparam logic [31:0]      NV_U      = NUM_VALVES;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);

    state_e                state_q;
    req_e                  last_q;
    logic                  servo_en_q;
    logic [VID_W-1:0]      servo_ch_q;
    logic                  servo_open_q;
    logic [NUM_VALVES-1:0] valve_state_q;
    logic [NUM_VALVES-1:0] valve_state_d;
    logic                  cmd_done_q;
    logic                  cmd_err_q;

    logic             idle;
    logic             gnt_man;
    logic             gnt_prg;
    logic             xfer;
    logic [VID_W-1:0] req_id;
    logic             req_open;
    logic             in_range;
    logic             cur_open;
    logic             needs_drive;
    logic             tmr_zero;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;

    assign idle    = (state_q == ST_IDLE);
    assign gnt_man = bus.man_valid && (!bus.prg_valid || last_q == REQ_PRG);
    assign gnt_prg = bus.prg_valid && !gnt_man;
    assign xfer    = idle && (gnt_man || gnt_prg);

    assign bus.prg_ready = idle && gnt_prg;
    assign bus.man_ready = idle && gnt_man;

    assign req_id   = gnt_man ? bus.man_valve : bus.prg_valve;
    assign req_open = gnt_man ? bus.man_open : bus.prg_open;
    assign in_range = (32'(req_id) < NV_U);

    // current commanded state of the requested valve and the updated vector
    always_comb begin
        cur_open      = 1'b0;
        valve_state_d = valve_state_q;
        for (int i = 0; i < NUM_VALVES; i++) begin
            if (req_id == VID_W'(i)) begin
                cur_open         = valve_state_q[i];
                valve_state_d[i] = req_open;
            end
        end
    end

    assign needs_drive = xfer && in_range && (cur_open != req_open);
    assign tmr_load    = needs_drive || (state_q == ST_DRIVE && tmr_zero);
    assign tmr_val     = needs_drive ? SETTLE_LD : GAP_LD;

    sched_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .dec_i     (!idle),
        .zero_o    (tmr_zero)
    );

    // arbitration pointer, command FSM and registered servo/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_q        <= REQ_MAN;
            servo_en_q    <= 1'b0;
            servo_ch_q    <= '0;
            servo_open_q  <= 1'b0;
            valve_state_q <= '0;
            cmd_done_q    <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            cmd_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        last_q <= gnt_man ? REQ_MAN : REQ_PRG;
                        if (!in_range) begin
                            cmd_done_q <= 1'b1;
                            cmd_err_q  <= 1'b1;
                        end else if (cur_open == req_open) begin
                            cmd_done_q <= 1'b1;
                        end else begin
                            state_q       <= ST_DRIVE;
                            valve_state_q <= valve_state_d;
                            servo_ch_q    <= req_id;
                            servo_open_q  <= req_open;
                            servo_en_q    <= 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (tmr_zero) begin
                        state_q    <= ST_GAP;
                        servo_en_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        state_q    <= ST_IDLE;
                        cmd_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.servo_en    = servo_en_q;
    assign bus.servo_ch    = servo_ch_q;
    assign bus.servo_open  = servo_open_q;
    assign bus.valve_state = valve_state_q;
    assign bus.busy        = !idle;
    assign bus.cmd_done    = cmd_done_q;
    assign bus.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_valve_cmd_scheduler.sv
// Scoreboard bench for valve_cmd_scheduler: directed scenarios then random traffic.
// A negedge monitor predicts grants, servo windows and completions from command history.
module tb_valve_cmd_scheduler;
    localparam int NV = 4;
    localparam int VW = 3;
    localparam int S  = 8;
    localparam int G  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    valve_cmd_scheduler_if #(.VID_W(VW), .NUM_VALVES(NV)) bus ();

    valve_cmd_scheduler #(
        .NUM_VALVES   (NV),
        .VID_W        (VW),
        .SETTLE_CYCLES(S),
        .GAP_CYCLES   (G),
        .CNT_W        (4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          t;
        int          lat;
        bit          err;
        logic [NV-1:0] st;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t        sbq[$];
    exp_t        e;
    logic [NV-1:0] m_state;
    bit          m_last_man;
    int          act_t;
    int          act_ch;
    bit          act_open;
    int          last_t;
    bit          exp_busy;
    bit          exp_en;
    bit          exp_pr;
    bit          exp_mr;
    bit          exp_done;
    bit          is_man;
    int          id;
    bit          op;

    task automatic chk(input string nm, input int a, input int x);
        checks++;
        if (a != x) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d cyc=%0d", nm, a, x, cyc);
        end
    endtask

    function automatic void model_reset();
        sbq.delete();
        m_state    = '0;
        m_last_man = 1'b1;
        act_t      = -1000;
        last_t     = -1000;
    endfunction

    always @(posedge clk) cyc++;

    // monitor: compares every cycle against the command-history model
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            exp_done = sbq.size() > 0 && (cyc - sbq[0].t == sbq[0].lat);
            chk("done_pulse", int'(bus.cmd_done), int'(exp_done));
            chk("err_alone", int'(bus.cmd_err && !bus.cmd_done), 0);
            if (sbq.size() > 0 &&
                (bus.cmd_done || cyc - sbq[0].t >= sbq[0].lat)) begin
                e = sbq.pop_front();
                if (bus.cmd_done) begin
                    chk("done_latency", cyc - e.t, e.lat);
                    chk("done_err", int'(bus.cmd_err), int'(e.err));
                    chk("done_state", int'(bus.valve_state), int'(e.st));
                end
            end
            exp_busy = cyc >= act_t && cyc < act_t + S + G;
            exp_en   = cyc >= act_t && cyc < act_t + S;
            chk("busy", int'(bus.busy), int'(exp_busy));
            chk("servo_en", int'(bus.servo_en), int'(exp_en));
            if (exp_en) begin
                chk("servo_ch", int'(bus.servo_ch), act_ch);
                chk("servo_open", int'(bus.servo_open), int'(act_open));
            end
            if (cyc >= last_t)
                chk("valve_state", int'(bus.valve_state), int'(m_state));
            if (exp_busy) begin
                exp_pr = 1'b0;
                exp_mr = 1'b0;
            end else begin
                exp_mr = bus.man_valid && (!bus.prg_valid || !m_last_man);
                exp_pr = bus.prg_valid && !exp_mr;
            end
            chk("prg_ready", int'(bus.prg_ready), int'(exp_pr));
            chk("man_ready", int'(bus.man_ready), int'(exp_mr));
            if ((bus.prg_valid && bus.prg_ready) ||
                (bus.man_valid && bus.man_ready)) begin
                is_man = !(bus.prg_valid && bus.prg_ready);
                id     = is_man ? int'(bus.man_valve) : int'(bus.prg_valve);
                op     = is_man ? bus.man_open : bus.prg_open;
                e.t    = cyc + 1;
                e.err  = 1'b0;
                e.lat  = 0;
                m_last_man = is_man;
                last_t     = cyc + 1;
                if (id >= NV) begin
                    e.err = 1'b1;
                end else if (m_state[id] != op) begin
                    m_state[id] = op;
                    e.lat    = S + G;
                    act_t    = cyc + 1;
                    act_ch   = id;
                    act_open = op;
                end
                e.st = m_state;
                sbq.push_back(e);
            end
        end
    end

    // present one command and hold it until accepted (call at posedge+#1)
    task automatic send(input bit man, input int vid, input bit o);
        int n = 0;
        if (man) begin
            bus.man_valid = 1'b1;
            bus.man_valve = VW'(vid);
            bus.man_open  = o;
        end else begin
            bus.prg_valid = 1'b1;
            bus.prg_valve = VW'(vid);
            bus.prg_open  = o;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!(man ? bus.man_ready : bus.prg_ready) && n < 400);
        if (!(man ? bus.man_ready : bus.prg_ready)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout req=%0d act=0 exp=1", man);
        end
        @(posedge clk);
        #1;
        if (man) bus.man_valid = 1'b0;
        else     bus.prg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sbq.size() != 0 || bus.busy) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout act=%0d exp=0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.prg_valid = 1'b0;
        bus.prg_valve = '0;
        bus.prg_open  = 1'b0;
        bus.man_valid = 1'b0;
        bus.man_valve = '0;
        bus.man_open  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_servo_en", int'(bus.servo_en), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_state", int'(bus.valve_state), 0);
        chk("rst_done", int'(bus.cmd_done), 0);
        chk("rst_ch", int'(bus.servo_ch), 0);
        chk("rst_ready", int'(bus.prg_ready | bus.man_ready), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        fork
            send(1'b0, 1, 1'b1);
            send(1'b1, 3, 1'b1);
        join
        wait_idle();
        chk("both_final_state", int'(bus.valve_state), 4'b1010);

        send(1'b0, 2, 1'b1);
        wait_idle();
        chk("open2_state", int'(bus.valve_state), 4'b1110);

        send(1'b0, 0, 1'b0);
        wait_idle();

        send(1'b1, 5, 1'b1);
        wait_idle();
        chk("bad_id_state", int'(bus.valve_state), 4'b1110);

        send(1'b0, 0, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_servo_en", int'(bus.servo_en), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_state", int'(bus.valve_state), 0);
        chk("arst_done", int'(bus.cmd_done), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, 0, 1'b1);
        wait_idle();
        chk("post_rst_state", int'(bus.valve_state), 4'b0001);

        fork
            send(1'b0, 1, 1'b1);
            begin
                @(posedge clk);
                #1;
                send(1'b1, 2, 1'b1);
            end
        join
        wait_idle();
        chk("held_man_state", int'(bus.valve_state), 4'b0111);

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    #1;
                    send(1'b0, int'($urandom_range(0, 5)),
                         1'($urandom_range(0, 1)));
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    #1;
                    send(1'b1, int'($urandom_range(0, 5)),
                         1'($urandom_range(0, 1)));
                end
            end
        join
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
